muldiv_seq: RTL and testbench

- Multi-cycle radix-2 divide unit for the RISC-V M extension (DIV/DIVU/REM/REMU), with a valid/ready handshake.
- Accepts operands and MDFunc from the register-read/decode stage and returns a 32-bit result to the writeback mux, replacing the combinational divide path.
- The pipeline stalls on in_ready/out_valid.
- Multiplies are optionally iterated here too (see Optional Feature).

---
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 DIV/DIVU/REM/REMU unit with valid/ready handshake.
// Define MULDIV_SEQ_MUL_EN to also iterate MUL/MULH/MULHSU/MULHU here; otherwise
// multiply funct3 codes complete at once with a zero result.
module muldiv_seq #(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic [2:0]        MDFunc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] MDOut,
    output logic              busy
);
`ifdef MULDIV_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int CW = $clog2(DWIDTH);
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            state_q;
    logic [DWIDTH-1:0] quot_q, rem_q, b_q, out_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        func_q;
    logic              negq_q, negr_q, in_ready_q, out_valid_q, busy_q;
    logic              sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, special;
    logic [DWIDTH-1:0] a_mag, b_mag, special_res;
    logic [DWIDTH:0]   rem_sh, diff, sum;
    logic [DWIDTH-1:0] div_rem_d, div_quot_d, mul_rem_d, mul_quot_d;
    logic [DWIDTH-1:0] quot_f, rem_f, fix_res;
    logic [2*DWIDTH-1:0] full_n;
    // Decode an incoming request: operand signedness, magnitudes and the single-cycle special cases
    always_comb begin
        sgn_a       = MDFunc[2] ? ~MDFunc[0] : (MDFunc[1] ^ MDFunc[0]);
        sgn_b       = MDFunc[2] ? ~MDFunc[0] : (MDFunc[1:0] == 2'b01);
        a_neg       = sgn_a & A[DWIDTH-1];
        b_neg       = sgn_b & B[DWIDTH-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
        div_zero    = (B == '0);
        div_ovf     = ~MDFunc[0] & (A == MIN_NEG) & (&B);
        special     = MDFunc[2] ? (div_zero | div_ovf) : ~MUL_EN;
        special_res = ~MDFunc[2] ? '0 :
                      div_zero   ? (MDFunc[1] ? A : '1) :
                                   (MDFunc[1] ? '0 : MIN_NEG);
    end
    // One restoring-divide step and one shift-add multiply step on the shared registers
    always_comb begin
        rem_sh     = {rem_q, quot_q[DWIDTH-1]};
        diff       = rem_sh - {1'b0, b_q};
        div_rem_d  = diff[DWIDTH] ? rem_sh[DWIDTH-1:0] : diff[DWIDTH-1:0];
        div_quot_d = {quot_q[DWIDTH-2:0], ~diff[DWIDTH]};
        sum        = {1'b0, rem_q} + (quot_q[0] ? {1'b0, b_q} : '0);
        mul_rem_d  = sum[DWIDTH:1];
        mul_quot_d = {sum[0], quot_q[DWIDTH-1:1]};
    end
    // Sign correction and result selection applied in FIX
    always_comb begin
        quot_f  = negq_q ? -quot_q : quot_q;
        rem_f   = negr_q ? -rem_q : rem_q;
        full_n  = negq_q ? -{rem_q, quot_q} : {rem_q, quot_q};
        fix_res = func_q[2] ? (func_q[1] ? rem_f : quot_f) :
                  (func_q[1:0] == 2'b00) ? full_n[DWIDTH-1:0] : full_n[2*DWIDTH-1:DWIDTH];
    end
    // Control FSM with registered handshake outputs; flush overrides every other event
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            quot_q      <= '0;
            rem_q       <= '0;
            b_q         <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            func_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    func_q     <= MDFunc;
                    in_ready_q <= 1'b0;
                    if (special) begin
                        state_q     <= DONE;
                        out_q       <= special_res;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(DWIDTH - 1);
                        quot_q  <= a_mag;
                        b_q     <= b_mag;
                        rem_q   <= '0;
                        negq_q  <= a_neg ^ b_neg;
                        negr_q  <= a_neg;
                    end
                end
                CALC: begin
                    quot_q <= func_q[2] ? div_quot_d : mul_quot_d;
                    rem_q  <= func_q[2] ? div_rem_d : mul_rem_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    state_q     <= DONE;
                    out_q       <= fix_res;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign MDOut     = out_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq results, latency, backpressure, flush and reset.
module tb_muldiv_seq;
    logic        clock = 1'b0, reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] op_a, op_b, md_out;
    logic [2:0]  md_func;
    int          passed = 0, total = 0;
    muldiv_seq #(.DWIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A(op_a), .B(op_b), .MDFunc(md_func), .out_valid(out_valid), .out_ready(out_ready),
        .MDOut(md_out), .busy(busy)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        md_func  = f;
        op_a     = a;
        op_b     = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        md_func  = ~f;
    endtask
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 1;
        check({tag, "_busy"}, 32'(busy), 32'(exp_lat != 1));
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        start_op(f, a, b);
        wait_result(tag, exp_lat);
        check(tag, md_out, exp);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask
    initial begin
        int cnt;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; md_func = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mdout", md_out, 32'd0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        run_op("div_p_n", 3'b100, 32'd120, 32'hFFFF_FFE8, 32'hFFFF_FFFB, 34);
        run_op("rem_p_n", 3'b110, 32'd120, 32'hFFFF_FFE8, 32'h0, 34);
        run_op("div_n_p", 3'b100, 32'hFFFF_FFE8, 32'd120, 32'h0, 34);
        run_op("rem_n_p", 3'b110, 32'hFFFF_FFE8, 32'd120, 32'hFFFF_FFE8, 34);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu_big", 3'b101, 32'd120, 32'hFFFF_FFE8, 32'h0, 34);
        run_op("remu_big", 3'b111, 32'd120, 32'hFFFF_FFE8, 32'd120, 34);
        run_op("divu_16", 3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
        run_op("remu_16", 3'b111, 32'hFFFF_FFFF, 32'd16, 32'd15, 34);
        run_op("divu_min", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
        run_op("remu_min", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("divu_z", 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_z", 3'b110, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
`ifdef MULDIV_SEQ_MUL_EN
        run_op("mul", 3'b000, 32'd120, 32'hFFFF_FFE8, 32'hFFFF_F4C0, 34);
        run_op("mulh", 3'b001, 32'd120, 32'hFFFF_FFE8, 32'hFFFF_FFFF, 34);
        run_op("mulhsu", 3'b010, 32'd120, 32'hFFFF_FFE8, 32'h0000_0077, 34);
        run_op("mulhu", 3'b011, 32'd120, 32'hFFFF_FFE8, 32'h0000_0077, 34);
`else
        run_op("mul_off", 3'b000, 32'd120, 32'hFFFF_FFE8, 32'h0, 1);
`endif
        start_op(3'b100, 32'd120, 32'hFFFF_FFE8);
        wait_result("bp", 34);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (out_valid && !in_ready && md_out == 32'hFFFF_FFFB) cnt++;
        end
        check("bp_stable", cnt, 10);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready", 32'(in_ready), 32'd1);
        check("bp_out_valid", 32'(out_valid), 32'd0);
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_busy", 32'(busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) cnt++;
        end
        check("fl_no_valid", cnt, 0);
        check("fl_mdout_kept", md_out, 32'hFFFF_FFFB);
        in_valid = 1'b1; flush = 1'b1; md_func = 3'b101; op_a = 32'd50; op_b = 32'd7;
        @(posedge clock);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("fl_idle_busy", 32'(busy), 32'd0);
        check("fl_idle_ready", 32'(in_ready), 32'd1);
        run_op("fl_next", 3'b101, 32'd1000, 32'd3, 32'd333, 34);
        start_op(3'b111, 32'd1000, 32'd3);
        wait_result("fl_done", 34);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        check("fl_done_valid", 32'(out_valid), 32'd0);
        check("fl_done_ready", 32'(in_ready), 32'd1);
        start_op(3'b100, 32'd120, 32'd7);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_mdout", md_out, 32'd0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        run_op("ar_next", 3'b100, 32'd120, 32'd7, 32'd17, 34);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
